// File: rtl/mem_access.sv
// mem_access: MEM stage running loads/stores on a req/ack bus; stalls upstream while a transaction is outstanding.
// Result in the DONE cycle (ack in k-th BUSY cycle -> k+2); define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_sdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack,
  output logic        bus_err,
  output logic        align_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rd_buf;
  logic             aborted;

  logic        is_load, is_store, is_byte, is_half, is_word, is_signed, mem_valid;
  logic        misaligned, timeout_hit;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, load_val;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    case (ex_mem_op)
      4'd1: begin is_load = 1'b1;  is_byte = 1'b1; is_signed = 1'b1; end
      4'd2: begin is_load = 1'b1;  is_byte = 1'b1; end
      4'd3: begin is_load = 1'b1;  is_half = 1'b1; is_signed = 1'b1; end
      4'd4: begin is_load = 1'b1;  is_half = 1'b1; end
      4'd5: begin is_load = 1'b1;  is_word = 1'b1; end
      4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
      4'd7: begin is_store = 1'b1; is_half = 1'b1; end
      4'd8: begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign mem_valid   = is_load | is_store;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_half & ex_mem_addr[0]) | (is_word & (ex_mem_addr[1:0] != 2'b00));
  assign align_err  = (state == IDLE) & mem_valid & misaligned;
`else
  assign misaligned = 1'b0;
  assign align_err  = 1'b0;
`endif

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    sel_c   = 4'b0000;
    wdata_c = 32'h0;
    if (is_byte)      sel_c = 4'b1000 >> ex_mem_addr[1:0];
    else if (is_half) sel_c = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
    else if (is_word) sel_c = 4'b1111;
    if (is_store) begin
      if (is_byte)      wdata_c = {4{ex_mem_sdata[7:0]}};
      else if (is_half) wdata_c = {2{ex_mem_sdata[15:0]}};
      else              wdata_c = ex_mem_sdata;
    end
  end

  always_comb begin
    case (ex_mem_addr[1:0])
      2'd0:    lane_b = rd_buf[31:24];
      2'd1:    lane_b = rd_buf[23:16];
      2'd2:    lane_b = rd_buf[15:8];
      default: lane_b = rd_buf[7:0];
    endcase
    lane_h = ex_mem_addr[1] ? rd_buf[15:0] : rd_buf[31:16];
    if (is_byte)      load_val = {{24{is_signed & lane_b[7]}}, lane_b};
    else if (is_half) load_val = {{16{is_signed & lane_h[15]}}, lane_h};
    else              load_val = rd_buf;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    stallreq  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid && misaligned) begin
          mem_wreg = 1'b0;
        end else if (mem_valid) begin
          stallreq  = 1'b1;
          mem_wreg  = 1'b0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stallreq = 1'b1;
        mem_wreg = 1'b0;
        if (dbus_ack || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        if (is_load && !aborted) mem_wdata = load_val;
        else                     mem_wreg  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rd_buf     <= 32'h0;
      aborted    <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= 32'h0;
      dbus_sel   <= 4'h0;
      dbus_wdata <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (mem_valid && !misaligned) begin
          dbus_req   <= 1'b1;
          dbus_we    <= is_store;
          dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
          dbus_sel   <= sel_c;
          dbus_wdata <= wdata_c;
          cnt        <= '0;
          aborted    <= 1'b0;
        end
        BUSY: begin
          // An ack in the final allowed cycle takes priority over the abort.
          if (dbus_ack) begin
            rd_buf   <= dbus_rdata;
            dbus_req <= 1'b0;
          end else if (timeout_hit) begin
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            aborted  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: constant vector table, reset/abort sequences, random loads/stores vs a model.
module tb_mem_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr, ex_mem_sdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_sel;
  logic        dbus_ack, bus_err, align_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .bus_err(bus_err), .align_err(align_err)
  );

  typedef struct {
    int          stall, req, berr, align;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] daddr, dwdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    bit          hung, issued, chk_wdata;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata;
    int          ack;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] daddr, dwdata;
    logic        wreg;
    logic [31:0] res;
    int          stall, berr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one held instruction until stallreq drops, then one idle cycle.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, sdata, rdata,
                         input int ack_k, input bit spur, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] wdata, output res_t r);
    bit done = 0;
    r = '{default: 0};
    for (int c = 0; c < TO + 6 && !done; c++) begin
      @(negedge clk);
      ex_mem_op = op; ex_mem_addr = addr; ex_mem_sdata = sdata;
      ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
      dbus_ack   = (ack_k > 0 && c == ack_k) || (spur && c == 0);
      dbus_rdata = (ack_k > 0 && c == ack_k) ? rdata : $urandom;
      #1;
      if (align_err) r.align++;
      if (dbus_req)  r.req++;
      if (bus_err)   r.berr++;
      if (c == 1) begin
        r.sel = dbus_sel; r.we = dbus_we; r.daddr = dbus_addr; r.dwdata = dbus_wdata;
      end
      if (!stallreq) begin
        r.wd = mem_wd; r.wreg = mem_wreg; r.wdata = mem_wdata;
        done = 1;
      end else begin
        r.stall++;
      end
    end
    r.hung = !done;
    @(negedge clk);
    ex_mem_op = 4'd0; dbus_ack = 1'b0;
    #1;
    if (dbus_req) r.req++;
    if (bus_err)  r.berr++;
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [31:0] addr, sdata, rdata,
                                 input int ack_k, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata);
    res_t e;
    int size, off, n;
    bit ld, st, sgn, mis, acked;
    logic [31:0] mask, v;
    e = '{default: 0};
    ld   = op >= 1 && op <= 5;
    st   = op >= 6 && op <= 8;
    size = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
    sgn  = op == 1 || op == 3;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_wdata = 1;
    if (!(ld || st)) return e;
    mis = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`endif
    e.wreg = 0; e.chk_wdata = 0;
    if (mis) begin
      e.align = 1;
      return e;
    end
    acked = ack_k >= 1 && ack_k <= TO;
    n = acked ? ack_k : TO;
    e.stall = n + 1; e.req = n; e.berr = acked ? 0 : 1;
    e.issued = 1; e.we = st;
    off = (size == 1) ? int'(addr[1:0]) : (size == 2) ? 2 * int'(addr[1]) : 0;
    e.sel   = 4'(((1 << size) - 1) << (4 - size - off));
    e.daddr = addr & ~32'h3;
    if (size == 1)      e.dwdata = sdata[7:0] * 32'h01010101;
    else if (size == 2) e.dwdata = sdata[15:0] * 32'h00010001;
    else                e.dwdata = sdata;
    if (ld && acked) begin
      mask = (size == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * size)) - 1);
      v = (rdata >> (8 * (4 - size - off))) & mask;
      if (sgn && v[8 * size - 1]) v = v | ~mask;
      e.wreg = wreg; e.wdata = v; e.chk_wdata = 1;
    end
    return e;
  endfunction

  task automatic cmp(input string tag, input res_t a, input res_t e);
    check({tag, "_hung"},  32'(a.hung), 32'(e.hung));
    check({tag, "_stall"}, a.stall, e.stall);
    check({tag, "_req"},   a.req, e.req);
    check({tag, "_berr"},  a.berr, e.berr);
    check({tag, "_align"}, a.align, e.align);
    check({tag, "_wd"},    32'(a.wd), 32'(e.wd));
    check({tag, "_wreg"},  32'(a.wreg), 32'(e.wreg));
    if (e.chk_wdata) check({tag, "_wdata"}, a.wdata, e.wdata);
    if (e.issued) begin
      check({tag, "_sel"},   32'(a.sel), 32'(e.sel));
      check({tag, "_we"},    32'(a.we), 32'(e.we));
      check({tag, "_daddr"}, a.daddr, e.daddr);
      if (e.we) check({tag, "_dwdata"}, a.dwdata, e.dwdata);
    end
  endtask

  initial begin
    vec_t vecs[10];
    res_t r;
    logic [3:0] op;
    logic [31:0] addr, sdata, rdata, wdata;
    int ack_k;

    vecs[0] = '{4'd1, 32'h101, 32'h0, 32'h00F10000, 3, 4'b0100, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFFFFF1, 4, 0};
    vecs[1] = '{4'd2, 32'h101, 32'h0, 32'h00F10000, 3, 4'b0100, 1'b0, 32'h100, 32'h0, 1'b1, 32'h000000F1, 4, 0};
    vecs[2] = '{4'd7, 32'h202, 32'hABCD1234, 32'h0, 2, 4'b0011, 1'b1, 32'h200, 32'h12341234, 1'b0, 32'h0, 3, 0};
    vecs[3] = '{4'd3, 32'h100, 32'h0, 32'h80010000, 1, 4'b1100, 1'b0, 32'h100, 32'h0, 1'b1, 32'hFFFF8001, 2, 0};
    vecs[4] = '{4'd4, 32'h102, 32'h0, 32'h1234F00F, 2, 4'b0011, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000F00F, 3, 0};
    vecs[5] = '{4'd5, 32'h3FC, 32'h0, 32'hDEADBEEF, TO, 4'b1111, 1'b0, 32'h3FC, 32'h0, 1'b1, 32'hDEADBEEF, TO + 1, 0};
    vecs[6] = '{4'd6, 32'h003, 32'h0000005A, 32'h0, 1, 4'b0001, 1'b1, 32'h000, 32'h5A5A5A5A, 1'b0, 32'h0, 2, 0};
    vecs[7] = '{4'd8, 32'h010, 32'hCAFEF00D, 32'h0, 1, 4'b1111, 1'b1, 32'h010, 32'hCAFEF00D, 1'b0, 32'h0, 2, 0};
    vecs[8] = '{4'd1, 32'h000, 32'h0, 32'h7F000000, 1, 4'b1000, 1'b0, 32'h000, 32'h0, 1'b1, 32'h0000007F, 2, 0};
    vecs[9] = '{4'd5, 32'h400, 32'h0, 32'h0, 0, 4'b1111, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, TO + 1, 1};

    rst = 1'b1; dbus_ack = 1'b0; dbus_rdata = 32'h0;
    ex_wd = 5'd0; ex_wreg = 1'b0; ex_wdata = 32'h0;
    ex_mem_op = 4'd5; ex_mem_addr = 32'h104; ex_mem_sdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req",   32'(dbus_req), 32'h0);
    check("rst_we",    32'(dbus_we), 32'h0);
    check("rst_sel",   32'(dbus_sel), 32'h0);
    check("rst_addr",  dbus_addr, 32'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    check("rst_berr",  32'(bus_err), 32'h0);
    @(negedge clk);
    rst = 1'b0; ex_mem_op = 4'd0;

    run_txn(4'd0, 32'h0, 32'h0, 32'h0, 0, 1'b1, 5'd3, 1'b1, 32'h1234, r);
    check("nop_stall", r.stall, 0);
    check("nop_req",   r.req, 0);
    check("nop_wd",    32'(r.wd), 32'd3);
    check("nop_wreg",  32'(r.wreg), 32'd1);
    check("nop_wdata", r.wdata, 32'h1234);

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].rdata, vecs[i].ack, 1'b0,
              5'(i + 1), 1'b1, 32'h5555AAAA, r);
      check({t, "_sel"},   32'(r.sel), 32'(vecs[i].sel));
      check({t, "_we"},    32'(r.we), 32'(vecs[i].we));
      check({t, "_daddr"}, r.daddr, vecs[i].daddr);
      if (vecs[i].we) check({t, "_dwdata"}, r.dwdata, vecs[i].dwdata);
      check({t, "_stall"}, r.stall, vecs[i].stall);
      check({t, "_req"},   r.req, vecs[i].stall - 1);
      check({t, "_berr"},  r.berr, vecs[i].berr);
      check({t, "_wd"},    32'(r.wd), i + 1);
      check({t, "_wreg"},  32'(r.wreg), 32'(vecs[i].wreg));
      if (vecs[i].wreg) check({t, "_res"}, r.wdata, vecs[i].res);
    end

    // Reset during the second BUSY cycle, then a late ack that must be ignored.
    @(negedge clk);
    ex_mem_op = 4'd5; ex_mem_addr = 32'h40; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'h77;
    #1 check("mrst_idle_stall", 32'(stallreq), 32'd1);
    @(negedge clk);
    #1 check("mrst_busy_req", 32'(dbus_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ex_mem_op = 4'd0; dbus_ack = 1'b1; dbus_rdata = 32'h5555;
    #1;
    check("mrst_req",   32'(dbus_req), 32'd0);
    check("mrst_stall", 32'(stallreq), 32'd0);
    check("mrst_wreg",  32'(mem_wreg), 32'd1);
    check("mrst_wdata", mem_wdata, 32'h77);
    @(negedge clk);
    dbus_ack = 1'b0;
    #1;
    check("mrst_late_req",  32'(dbus_req), 32'd0);
    check("mrst_late_stall", 32'(stallreq), 32'd0);
    check("mrst_late_berr", 32'(bus_err), 32'd0);

    run_txn(4'd5, 32'h102, 32'h0, 32'h01234567, 2, 1'b0, 5'd4, 1'b1, 32'h99, r);
    cmp("misalign_lw", r, model(4'd5, 32'h102, 32'h0, 32'h01234567, 2, 5'd4, 1'b1, 32'h99));
`ifdef MEM_ALIGN_CHECK_EN
    check("misalign_flag", r.align, 1);
`else
    check("misalign_flag", r.align, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      op    = 4'($urandom_range(0, 15));
      addr  = $urandom;
      sdata = $urandom;
      rdata = $urandom;
      wdata = $urandom;
      ack_k = $urandom_range(0, TO + 2);
      run_txn(op, addr, sdata, rdata, ack_k, 1'($urandom_range(0, 1)), 5'(i), 1'b1, wdata, r);
      cmp($sformatf("rnd%0d", i), r, model(op, addr, sdata, rdata, ack_k, 5'(i), 1'b1, wdata));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
